// File: rtl/drum_pattern_recorder.sv
// drum_pattern_recorder: record side of the step-sequencer drum ring.
// Synchronizes an asynchronous tap input, quantizes each tap to a step of
// a free-running step sequencer, stores it in a STEPS-bit pattern and plays
// the pattern back as one-cycle trigger pulses.
// Optional build macro: DRUM_QUANTIZE_NEAREST_EN selects nearest-step
// quantization instead of the default floor quantization.
module drum_pattern_recorder #(
    parameter int STEPS = 8,
    parameter int DIV_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic                     tap_in,
    input  logic                     clear,
    input  logic [DIV_W-1:0]         step_period,
    output logic [STEPS-1:0]         pattern_out,
    output logic [$clog2(STEPS)-1:0] step_idx,
    output logic                     step_pulse,
    output logic                     trig_out,
    output logic                     rec_strobe
);

    localparam int IW = $clog2(STEPS);

    // Tap synchronizer and edge detect
    logic             sync1_q;
    logic             sync2_q;
    logic             edge_q;
    logic             tap_rise;

    // Step sequencer
    logic [DIV_W-1:0] div_q, div_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    idx_next;
    logic [DIV_W-1:0] period_eff;
    logic             terminal;
    logic             pulse;

    // Pattern store and playback
    logic [STEPS-1:0] pat_q, pat_d;
    logic             rec_q, rec_d;
    logic             trig_q, trig_d;
    logic [IW-1:0]    tgt;

    // Two-flop synchronizer plus edge-detect flop; runs regardless of ena
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= tap_in;
            sync2_q <= sync1_q;
            edge_q  <= sync2_q;
        end
    end

    assign tap_rise = sync2_q & ~edge_q;

    // A period of zero behaves as one; using >= also catches a counter left
    // beyond the terminal value after the period is shortened
    assign period_eff = (step_period == '0) ? DIV_W'(1) : step_period;
    assign terminal   = (div_q >= (period_eff - DIV_W'(1)));
    assign idx_next   = idx_q + IW'(1);

    // step_pulse is combinational from state; gated by rst_n so it reads 0
    // while reset is held even when the period is 1
    assign pulse = rst_n & ena & terminal;

    // Divider and step index next state
    always_comb begin
        div_d = div_q;
        idx_d = idx_q;
        if (ena) begin
            if (terminal) begin
                div_d = '0;
                idx_d = idx_next;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end
    end

    // Quantization target for a tap seen this cycle
`ifdef DRUM_QUANTIZE_NEAREST_EN
    logic late_tap;
    assign late_tap = (div_q >= (period_eff >> 1));
    assign tgt      = late_tap ? idx_next : idx_q;
`else
    assign tgt = idx_q;
`endif

    // Pattern write / clear and playback trigger next state
    always_comb begin
        pat_d = pat_q;
        rec_d = 1'b0;
        if (clear) begin
            pat_d = '0;
        end else if (ena && tap_rise) begin
            pat_d = pat_q | (STEPS'(1) << tgt);
            rec_d = 1'b1;
        end
        // Playback looks at the step being entered, including this cycle's write/clear
        trig_d = pulse & pat_d[idx_next];
    end

    // Sequencer, pattern and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            idx_q  <= '0;
            pat_q  <= '0;
            rec_q  <= 1'b0;
            trig_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            idx_q  <= idx_d;
            pat_q  <= pat_d;
            rec_q  <= rec_d;
            trig_q <= trig_d;
        end
    end

    assign pattern_out = pat_q;
    assign step_idx    = idx_q;
    assign step_pulse  = pulse;
    assign trig_out    = trig_q;
    assign rec_strobe  = rec_q;

endmodule
